pc_gen: RTL and testbench

- Parametrised pre-IF program-counter generator for the pipelined RV32I core with exceptions and interrupts.
- Produces the fetch address and selects the next PC by priority: trap > mret > branch > sequential.
- Computes direct or vectored trap targets from mtvec.
- If a redirect arrives while IF is stalled, it is buffered, so the presented PC stays stable until IF accepts it.

---
 rtl/pc_gen.sv | 104 ++++++++++
 tb/tb_pc_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Pre-IF program-counter generator: presents the fetch address and picks the next PC
// by trap > mret > branch > sequential, buffering redirects that arrive while IF stalls.
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              INST_BYTES  = 4,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_allow_in,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  input  logic            trap_valid,
  input  logic            trap_is_irq,
  input  logic [4:0]      trap_cause,
  input  logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] pc,
  output logic            pre_if_valid,
  output logic            fetch_misaligned,
  output logic            redirect_pending
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state;
  logic [1:0]      pend_prio;
  logic [XLEN-1:0] pend_target;

  logic            req;
  logic [1:0]      win_prio;
  logic [XLEN-1:0] win_target;
  logic            take_new;

  // Vectored mode only applies to interrupts; MODE 2'b10/2'b11 fall back to direct.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic            is_irq,
                                                  input logic [4:0]      cause);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (VECTORED_EN && tvec[1:0] == 2'b01 && is_irq)
      trap_target = base + (XLEN'(cause) << 2);
    else
      trap_target = base;
  endfunction

  always_comb begin
    req        = trap_valid | mret_valid | br_valid;
    win_prio   = 2'd0;
    win_target = '0;
    if (trap_valid) begin
      win_prio   = 2'd3;
      win_target = trap_target(mtvec, trap_is_irq, trap_cause);
    end else if (mret_valid) begin
      win_prio   = 2'd2;
      win_target = mepc;
    end else if (br_valid) begin
      win_prio   = 2'd1;
      win_target = br_target;
    end
    take_new = req && (win_prio >= pend_prio);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      pend_prio   <= 2'd0;
      pend_target <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (if_allow_in) begin
            pc <= req ? win_target : pc + XLEN'(INST_BYTES);
          end else if (req) begin
            pend_target <= win_target;
            pend_prio   <= win_prio;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (if_allow_in) begin
            pc        <= take_new ? win_target : pend_target;
            pend_prio <= 2'd0;
            state     <= RUN;
          end else if (take_new) begin
            pend_target <= win_target;
            pend_prio   <= win_prio;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign pre_if_valid     = (state == RUN);
  assign redirect_pending = (state == HOLD);
  assign fetch_misaligned = pre_if_valid && (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/boot, sequential fetch, stall and wrap, buffered
// redirects with priority override, vectored traps, simultaneous sources, async reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_allow_in;
  logic        br_valid;
  logic [31:0] br_target;
  logic        mret_valid;
  logic [31:0] mepc;
  logic        trap_valid;
  logic        trap_is_irq;
  logic [4:0]  trap_cause;
  logic [31:0] mtvec;

  logic [31:0] pc, pc_nv;
  logic        pre_if_valid, pre_if_valid_nv;
  logic        fetch_misaligned, fetch_misaligned_nv;
  logic        redirect_pending, redirect_pending_nv;

  int checks   = 0;
  int failures = 0;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .INST_BYTES(4), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_allow_in(if_allow_in),
    .br_valid(br_valid), .br_target(br_target),
    .mret_valid(mret_valid), .mepc(mepc),
    .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
    .mtvec(mtvec), .pc(pc), .pre_if_valid(pre_if_valid),
    .fetch_misaligned(fetch_misaligned), .redirect_pending(redirect_pending)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .INST_BYTES(4), .VECTORED_EN(1'b0)) dut_nv (
    .clk(clk), .rst_n(rst_n), .if_allow_in(if_allow_in),
    .br_valid(br_valid), .br_target(br_target),
    .mret_valid(mret_valid), .mepc(mepc),
    .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
    .mtvec(mtvec), .pc(pc_nv), .pre_if_valid(pre_if_valid_nv),
    .fetch_misaligned(fetch_misaligned_nv), .redirect_pending(redirect_pending_nv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid    = 1'b0;
    br_target   = '0;
    mret_valid  = 1'b0;
    mepc        = '0;
    trap_valid  = 1'b0;
    trap_is_irq = 1'b0;
    trap_cause  = '0;
    mtvec       = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    if_allow_in = 1'b1;
    idle_inputs();

    // Reset and boot cycle
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(pre_if_valid), 32'd0);
    check("rst_pending", 32'(redirect_pending), 32'd0);
    check("rst_misal", 32'(fetch_misaligned), 32'd0);
    rst_n = 1'b1;
    tick();
    check("boot_pc", pc, 32'h0);
    check("boot_valid", 32'(pre_if_valid), 32'd1);
    tick(); check("seq_4", pc, 32'h4);
    tick(); check("seq_8", pc, 32'h8);
    tick(); check("seq_c", pc, 32'hC);

    // Stall and wrap
    br_valid = 1'b1; br_target = 32'hFFFF_FFF8;
    tick(); check("br_fff8", pc, 32'hFFFF_FFF8);
    br_valid = 1'b0; if_allow_in = 1'b0;
    tick(); check("stall1", pc, 32'hFFFF_FFF8);
    tick(); check("stall2", pc, 32'hFFFF_FFF8);
    tick(); check("stall3", pc, 32'hFFFF_FFF8);
    check("stall_valid", 32'(pre_if_valid), 32'd1);
    if_allow_in = 1'b1;
    tick(); check("wrap_fffc", pc, 32'hFFFF_FFFC);
    tick(); check("wrap_0", pc, 32'h0);

    // Buffered redirect, trap override, lower-priority branch dropped
    if_allow_in = 1'b0; br_valid = 1'b1; br_target = 32'h100;
    tick();
    check("hold_pending", 32'(redirect_pending), 32'd1);
    check("hold_valid", 32'(pre_if_valid), 32'd0);
    check("hold_pc", pc, 32'h0);
    br_valid = 1'b0; trap_valid = 1'b1; trap_is_irq = 1'b0; mtvec = 32'h8000_0001;
    tick(); check("hold_pc2", pc, 32'h0);
    trap_valid = 1'b0; br_valid = 1'b1; br_target = 32'h300;
    tick(); check("hold_pending2", 32'(redirect_pending), 32'd1);
    br_valid = 1'b0; if_allow_in = 1'b1;
    tick();
    check("release_pc", pc, 32'h8000_0000);
    check("release_valid", 32'(pre_if_valid), 32'd1);
    check("release_pending", 32'(redirect_pending), 32'd0);

    // Vectored interrupt vs. non-vectored build
    trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 5'd7; mtvec = 32'h8000_0001;
    tick();
    check("vec_pc", pc, 32'h8000_001C);
    check("novec_pc", pc_nv, 32'h8000_0000);

    // Simultaneous sources
    trap_is_irq = 1'b0; trap_cause = 5'd0; mtvec = 32'h400;
    mret_valid = 1'b1; mepc = 32'h200; br_valid = 1'b1; br_target = 32'h300;
    tick(); check("all_three", pc, 32'h400);
    trap_valid = 1'b0;
    tick(); check("mret_br", pc, 32'h200);
    idle_inputs();
    tick(); check("after_mret", pc, 32'h204);

    // Async reset while a redirect is buffered
    if_allow_in = 1'b0; br_valid = 1'b1; br_target = 32'h100;
    tick(); check("hold_again", 32'(redirect_pending), 32'd1);
    br_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async_pc", pc, 32'h0);
    check("async_pending", 32'(redirect_pending), 32'd0);
    check("async_valid", 32'(pre_if_valid), 32'd0);
    rst_n = 1'b1; if_allow_in = 1'b1;
    tick(); check("reboot_pc", pc, 32'h0);
    tick(); check("no_stale_redirect", pc, 32'h4);

    // Misaligned target presented and flagged
    br_valid = 1'b1; br_target = 32'h102;
    tick();
    check("misal_pc", pc, 32'h102);
    check("misal_flag", 32'(fetch_misaligned), 32'd1);
    br_valid = 1'b0;
    tick();
    check("misal_seq", pc, 32'h106);
    check("misal_flag2", 32'(fetch_misaligned), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
